seq_divider: RTL

//   Sequential unsigned restoring divider. It is the inverse companion to the

---
 rtl/seq_divider.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential unsigned restoring divider. Each op produces one quotient bit per
// clock under a small IDLE -> ITER -> DONE control FSM. Operands are captured
// when start is seen in IDLE. The registered results are presented with a
// one-cycle ready pulse.
//
// Ports
//   clk          in   system clock, rising-edge active
//   rst          in   asynchronous reset, active-high
//   start        in   request a division (sampled only in IDLE)
//   dividend     in   [N-1:0] unsigned dividend, sampled with start
//   divisor      in   [N-1:0] unsigned divisor, sampled with start
//   quotient     out  [N-1:0] quotient of the last completed op (all ones on /0)
//   remainder    out  [N-1:0] remainder of the last completed op (dividend on /0)
//   busy         out  high from the accepting edge until the result is issued
//   ready        out  one-cycle pulse, results valid this cycle
//   div_by_zero  out  set with ready when the divisor was zero
//
// Latency: if start is accepted at edge k, ready is high in the cycle after
// edge k+N+1. For a zero divisor, ready is high in the cycle after edge k+1.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         ready,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_rem;    // partial remainder R; always < D between steps
  logic [N-1:0]   r_quo;    // Q: dividend bits shift out, quotient bits shift in
  logic [N-1:0]   r_div;    // D: captured divisor
  logic [CW-1:0]  r_count;  // iterations still to run
  logic           r_dbz;    // captured divisor was zero

  // The shifted partial remainder {R,Q} << 1 needs N+1 bits. The trial
  // subtraction is N+1 bits wide, so its MSB is the borrow. A stored R is
  // always < D, so its own MSB is always zero and R is kept N bits wide.
  logic [N:0]     w_rem_sh;
  logic [N:0]     w_trial;
  logic [N-1:0]   w_quo_sh;

  assign w_rem_sh = {r_rem, r_quo[N-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};
  assign w_quo_sh = r_quo << 1;

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; blocking ones would let later statements
  // see this cycle's new values and break the register semantics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_count     <= '0;
      r_dbz       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              // A zero divisor skips iteration. The dividend becomes the
              // remainder and the quotient is forced to all ones in DONE.
              r_rem   <= dividend;
              r_quo   <= '0;
              r_div   <= '0;
              r_count <= '0;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= dividend;
              r_div   <= divisor;
              r_count <= CW'(N);
              r_dbz   <= 1'b0;
              r_state <= S_ITER;
            end
          end
        end

        S_ITER: begin
          if (!w_trial[N]) begin
            // No borrow: the divisor fits, so keep the difference.
            r_rem <= w_trial[N-1:0];
            r_quo <= w_quo_sh | N'(1);
          end else begin
            r_rem <= w_rem_sh[N-1:0];
            r_quo <= w_quo_sh;
          end
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          quotient    <= r_dbz ? '1 : r_quo;
          remainder   <= r_rem;
          div_by_zero <= r_dbz;
          ready       <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
